fan_controller: RTL

Sequenced fan controller wrapped around the existing current-versus-preset temperature comparison. It accepts temperature samples over a valid/ready handshake and holds a loadable preset register. A four-state machine drives `fanOn` with minimum on and off times, plus optional hysteresis, so that a noisy sensor cannot chatter the fan. It sits between the sensor sampling logic and the fan driver output.

---
 rtl/fan_pkg.sv | 33 +++
 rtl/temp_compare.sv | 40 ++++
 rtl/fan_controller.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fan_pkg                                                   |
// | Purpose  : State encoding, default parameters and timer-width helper |
// |            shared by fan_controller and temp_compare.                |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package fan_pkg;

  // FSM encoding; bit 1 set means the fan is driven
  typedef enum logic [1:0] {
    OFF      = 2'd0,
    OFF_LOCK = 2'd1,
    ON_LOCK  = 2'd2,
    ON       = 2'd3
  } fan_state_e;

  localparam int unsigned c_temp_w_def     = 3;
  localparam int unsigned c_preset_rst_def = 3;
  localparam int unsigned c_min_on_def     = 8;
  localparam int unsigned c_min_off_def    = 4;
  localparam int unsigned c_hyst_def       = 1;

  // Lock timer width: clog2 of the longer lock period, plus one bit
  function automatic int unsigned fan_timer_w(input int unsigned min_on,
                                              input int unsigned min_off);
    int unsigned longest;
    longest = (min_on > min_off) ? min_on : min_off;
    return $clog2(longest) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/temp_compare.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : temp_compare                                              |
// | Purpose  : Combinational hot/cool decision of the latest sample      |
// |            against the preset. Macro FAN_HYST_EN enables the         |
// |            hysteresis band on the cool decision.                     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module temp_compare
  import fan_pkg::*;
#(
  parameter int unsigned TEMP_W = c_temp_w_def,
  parameter int unsigned HYST   = c_hyst_def
) (
  input  logic [TEMP_W-1:0] lastTemp_i,
  input  logic [TEMP_W-1:0] presetTemp_i,
  output logic              hot_o,
  output logic              cool_o
);

  localparam int unsigned SUM_W = TEMP_W + 1;

`ifdef FAN_HYST_EN
  localparam int unsigned HYST_EFF = HYST;
`else
  // Band collapses to zero; HYST stays referenced so both builds share one interface
  localparam int unsigned HYST_EFF = 0 * HYST;
`endif

  logic [SUM_W-1:0] w_sum;

  // Sum carries one extra bit so sample + band never wraps below the preset
  always_comb begin
    w_sum  = {1'b0, lastTemp_i} + SUM_W'(HYST_EFF);
    hot_o  = (lastTemp_i > presetTemp_i);
    cool_o = (w_sum <= {1'b0, presetTemp_i});
  end

endmodule
`default_nettype wire

// File: rtl/fan_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fan_controller                                            |
// | Purpose  : Sequenced fan control with minimum on/off lock periods,   |
// |            sample handshake and loadable preset. Optional macro      |
// |            FAN_HYST_EN adds a hysteresis band to the turn-off test.  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module fan_controller
  import fan_pkg::*;
#(
  parameter int unsigned TEMP_W     = c_temp_w_def,
  parameter int unsigned PRESET_RST = c_preset_rst_def,
  parameter int unsigned MIN_ON     = c_min_on_def,
  parameter int unsigned MIN_OFF    = c_min_off_def,
  parameter int unsigned HYST       = c_hyst_def
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              presetLoad,
  input  logic [TEMP_W-1:0] presetIn,
  input  logic              sampleValid,
  input  logic [TEMP_W-1:0] sampleTemp,
  output logic              sampleReady,
  output logic              fanOn,
  output logic [TEMP_W-1:0] presetTemp,
  output logic [1:0]        state
);

  localparam int unsigned     TMR_W      = fan_timer_w(MIN_ON, MIN_OFF);
  localparam logic [TMR_W-1:0] c_on_last  = TMR_W'(MIN_ON - 1);
  localparam logic [TMR_W-1:0] c_off_last = TMR_W'(MIN_OFF - 1);

  fan_state_e        state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [TMR_W-1:0]  w_timer_inc;
  logic [TEMP_W-1:0] lastTemp_q;
  logic [TEMP_W-1:0] presetTemp_q;
  logic              hasSample_q;
  logic              sampleReady_q;
  logic              w_accept;
  logic              w_hot;
  logic              w_cool;

  assign w_accept    = sampleValid && sampleReady_q;
  assign sampleReady = sampleReady_q;
  assign presetTemp  = presetTemp_q;
  assign state       = state_q;
  assign fanOn       = (state_q == ON_LOCK) || (state_q == ON);

  temp_compare #(
    .TEMP_W (TEMP_W),
    .HYST   (HYST)
  ) u_cmp (
    .lastTemp_i   (lastTemp_q),
    .presetTemp_i (presetTemp_q),
    .hot_o        (w_hot),
    .cool_o       (w_cool)
  );

  // Sample/preset registers; ready drops for one cycle after every accept
  always_ff @(posedge clk) begin
    if (reset) begin
      sampleReady_q <= 1'b0;
      lastTemp_q    <= '0;
      hasSample_q   <= 1'b0;
      presetTemp_q  <= TEMP_W'(PRESET_RST);
    end else begin
      sampleReady_q <= ~w_accept;
      if (w_accept) begin
        lastTemp_q  <= sampleTemp;
        hasSample_q <= 1'b1;
      end
      if (presetLoad) begin
        presetTemp_q <= presetIn;
      end
    end
  end

  // State and lock-timer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= OFF_LOCK;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Saturating increment; the timer must never wrap back into a lock window
  assign w_timer_inc = (timer_q == '1) ? timer_q : timer_q + TMR_W'(1);

  // Next state: lock states only count, free states only compare
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      OFF_LOCK: begin
        if (timer_q == c_off_last) begin
          state_d = OFF;
          timer_d = '0;
        end else begin
          timer_d = w_timer_inc;
        end
      end
      OFF: begin
        timer_d = '0;
        if (hasSample_q && w_hot) begin
          state_d = ON_LOCK;
        end
      end
      ON_LOCK: begin
        if (timer_q == c_on_last) begin
          state_d = ON;
          timer_d = '0;
        end else begin
          timer_d = w_timer_inc;
        end
      end
      ON: begin
        timer_d = '0;
        if (hasSample_q && w_cool) begin
          state_d = OFF_LOCK;
        end
      end
      default: begin
        state_d = OFF_LOCK;
        timer_d = '0;
      end
    endcase
  end

endmodule
`default_nettype wire
